// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
//
// Time-shares one external combinational approx_8x8 multiplier among N_REQ
// requesters. Requests arrive on per-requester valid/ready channels and are
// granted round-robin. The winner's operands are latched and held on
// mult_a/mult_b for MUL_LAT cycles, then mult_y is captured. The product goes
// out on one valid/ready response channel tagged with the requester index.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   ID_W     width of rsp_id (>= clog2(N_REQ))
//   MUL_LAT  cycles the operands are held before mult_y is sampled (1..15)
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero
//   req_a      operand A, requester i on bits [8i+7:8i]
//   req_b      operand B, same packing as req_a
//   rsp_valid  response valid
//   rsp_ready  consumer accepts the response
//   rsp_y      product as returned by the multiplier
//   rsp_id     index of the requester that owns rsp_y
//   rsp_err    |exact - approx| when the error checker is built, else 0
//   mult_a     operand A to the shared multiplier
//   mult_b     operand B to the shared multiplier
//   mult_y     shared multiplier output
//   busy       high whenever the controller is not idle
//
// Build option:
//   MULT_SHARE_ERR_CHECK_EN  when defined, an exact 8x8 multiplier compares
//                            against mult_y and reports the absolute error on
//                            rsp_err. When undefined rsp_err is constant 0.
// -----------------------------------------------------------------------------
module mult_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_err,
    output logic [7:0]           mult_a,
    output logic [7:0]           mult_b,
    input  logic [15:0]          mult_y,
    output logic                 busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ID_W-1:0]    id_reg;
    logic [7:0]         mult_a_reg;
    logic [7:0]         mult_b_reg;
    logic [15:0]        rsp_y_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic               rsp_valid_reg;

    // Unpacked views of the packed operand buses.
    logic [7:0]         op_a_arr [N_REQ];
    logic [7:0]         op_b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a_arr[gi] = req_a[8*gi +: 8];
            assign op_b_arr[gi] = req_b[8*gi +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin winner: first asserted req_valid at or above rr_ptr, wrapping.
    // scan_idx carries one extra bit so the wrap can be done by subtraction,
    // which also works when N_REQ is not a power of two.
    // -------------------------------------------------------------------------
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     scan_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // A grant is always a handshake: req_ready only goes to a requester whose
    // req_valid is high in the same cycle.
    logic               accept;
    logic [PTR_W-1:0]   rr_next;
    logic               cnt_done;

    assign accept   = (state_reg == IDLE) && grant_found;
    assign rr_next  = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    assign cnt_done = (cnt_reg == '0);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if (cnt_done) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and datapath. mult_a/mult_b only load on a grant, so they
    // keep the last operands while idle. cnt is loaded with MUL_LAT-1 so that
    // MUL lasts exactly MUL_LAT cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            id_reg        <= '0;
            mult_a_reg    <= '0;
            mult_b_reg    <= '0;
            rsp_y_reg     <= '0;
            rsp_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mult_a_reg <= op_a_arr[grant_idx];
                        mult_b_reg <= op_b_arr[grant_idx];
                        id_reg     <= ID_W'(grant_idx);
                        cnt_reg    <= CNT_W'(MUL_LAT - 1);
                        rr_ptr_reg <= rr_next;
                    end
                end
                MUL: begin
                    if (cnt_done) begin
                        rsp_y_reg     <= mult_y;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULT_SHARE_ERR_CHECK_EN
    // Exact reference product, compared against the approximate result at the
    // same edge that captures mult_y, so the error is valid with rsp_valid.
    logic [15:0] exact_prod;
    logic [15:0] abs_err;
    logic [15:0] rsp_err_reg;

    assign exact_prod = {8'd0, mult_a_reg} * {8'd0, mult_b_reg};
    assign abs_err    = (exact_prod >= mult_y) ? (exact_prod - mult_y)
                                               : (mult_y - exact_prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err_reg <= '0;
        end else if ((state_reg == MUL) && cnt_done) begin
            rsp_err_reg <= abs_err;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = '0;
`endif

    assign mult_a    = mult_a_reg;
    assign mult_b    = mult_b_reg;
    assign rsp_y     = rsp_y_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_valid = rsp_valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for mult_share_ctrl. Main instance (MUL_LAT=1) is checked every cycle
// against a transaction-level model; a second instance (MUL_LAT=4) gets
// directed checks for latency, the approximate 2x2 case and reset in MUL.
// -----------------------------------------------------------------------------
module tb_mult_share_ctrl;

    localparam int N  = 4;
    localparam int L1 = 1;
`ifdef MULT_SHARE_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance
    logic [N-1:0]   req_valid, req_ready;
    logic [8*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [15:0]    rsp_y, rsp_err, mult_y;
    logic [1:0]     rsp_id;
    logic [7:0]     mult_a, mult_b;
    logic           busy;

    // MUL_LAT=4 instance
    logic [N-1:0]   v2, rdy2;
    logic [8*N-1:0] a2, b2;
    logic           rv2, rr2;
    logic [15:0]    y2, err2, my2;
    logic [1:0]     id2;
    logic [7:0]     ma2, mb2;
    logic           busy2;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Approximate 8x8 built from 2-bit digit partial products, where 3*3 is
    // replaced by 7; every other digit product is exact.
    function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
        int s, da, db, p;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                da = (int'(a) >> (2*i)) & 3;
                db = (int'(b) >> (2*j)) & 3;
                p  = da * db;
                if (p == 9) p = 7;
                s += p << (2*(i+j));
            end
        end
        return s[15:0];
    endfunction

    function automatic logic [15:0] model_err(input logic [7:0] a, input logic [7:0] b);
        int e, x;
        e = int'(a) * int'(b);
        x = int'(approx_mul(a, b));
        if (!ERR_EN) return 16'd0;
        e = (e >= x) ? e - x : x - e;
        return e[15:0];
    endfunction

    assign mult_y = approx_mul(mult_a, mult_b);
    assign my2    = approx_mul(ma2, mb2);

    mult_share_ctrl #(.N_REQ(N), .ID_W(2), .MUL_LAT(L1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y), .busy(busy)
    );

    mult_share_ctrl #(.N_REQ(N), .ID_W(2), .MUL_LAT(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(rdy2), .req_a(a2), .req_b(b2),
        .rsp_valid(rv2), .rsp_ready(rr2), .rsp_y(y2), .rsp_id(id2),
        .rsp_err(err2), .mult_a(ma2), .mult_b(mb2), .mult_y(my2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model of the main instance: a job is taken when
    // idle, its result appears L1 edges later and is held until accepted.
    // ------------------------------------------------------------------
    bit          m_busy = 0, m_rv = 0;
    int          m_wait = 0, m_rr = 0, m_id = 0, m_rid = 0, mdl_w;
    logic [7:0]  m_ma = 0, m_mb = 0;
    logic [15:0] m_y = 0, m_err = 0;
    logic [17:0] rsp_log[$];

    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_y});
        if (!rst_n) begin
            m_busy = 0; m_rv = 0; m_wait = 0; m_rr = 0; m_id = 0; m_rid = 0;
            m_ma = 0; m_mb = 0; m_y = 0; m_err = 0;
        end else if (!m_busy) begin
            mdl_w = winner(req_valid, m_rr);
            if (mdl_w >= 0) begin
                m_ma   = req_a[8*mdl_w +: 8];
                m_mb   = req_b[8*mdl_w +: 8];
                m_id   = mdl_w;
                m_wait = 0;
                m_busy = 1;
                m_rr   = (mdl_w + 1) % N;
            end
        end else if (!m_rv) begin
            m_wait++;
            if (m_wait == L1) begin
                m_rv  = 1;
                m_y   = approx_mul(m_ma, m_mb);
                m_err = model_err(m_ma, m_mb);
                m_rid = m_id;
            end
        end else if (rsp_ready) begin
            m_rv   = 0;
            m_busy = 0;
            $display("[TB] txn id=%0d a=%0d b=%0d y=%0d err=%0d", m_rid, m_ma, m_mb, m_y, m_err);
        end
    end

    int          mon_w;
    logic [N-1:0] mon_rdy;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_w   = winner(req_valid, m_rr);
            mon_rdy = (!m_busy && mon_w >= 0) ? (N'(1) << mon_w) : '0;
            check("req_ready", req_ready, mon_rdy);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, m_rv);
            check("rsp_y", rsp_y, m_y);
            check("rsp_id", rsp_id, m_rid[1:0]);
            check("rsp_err", rsp_err, m_err);
            check("mult_a", mult_a, m_ma);
            check("mult_b", mult_b, m_mb);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers for the main instance
    // ------------------------------------------------------------------
    task automatic drive_until_idle(input int max_cycles);
        logic [N-1:0] hs;
        bit done = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clk);
            hs = req_ready & req_valid;
            #1;
            req_valid = req_valid & ~hs;
            if (req_valid == '0 && !busy) done = 1;
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic rand_phase(input int cycles);
        logic [N-1:0] hs;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            hs = req_ready & req_valid;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        req_valid[i]     = 1'b1;
                        req_a[8*i +: 8]  = 8'($urandom);
                        req_b[8*i +: 8]  = 8'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [N-1:0] hs;
        int g, got;
        int order[$];

        rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0;
        v2 = '0; a2 = '0; b2 = '0; rr2 = 0;

        // the reference multiplier itself
        check("model_3x3", approx_mul(8'd3, 8'd3), 16'd7);
        check("model_10x32", approx_mul(8'd10, 8'd32), 16'd320);
        check("model_12x13", approx_mul(8'd12, 8'd13), 16'd124);

        @(posedge clk); #1 mon_en = 1;
        @(posedge clk); #1 rst_n = 1;

        // reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst2_busy", busy2, 0);

        // single request, a=10 b=32
        @(posedge clk); #1;
        req_valid = 4'b0001; req_a[7:0] = 8'd10; req_b[7:0] = 8'd32; rsp_ready = 1;
        @(negedge clk) check("A_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("A_ready_drop", req_ready, 0);
        check("A_not_yet", rsp_valid, 0);
        check("A_busy", busy, 1);
        @(negedge clk);
        check("A_rsp_valid", rsp_valid, 1);
        check("A_rsp_y", rsp_y, 16'd320);
        check("A_rsp_id", rsp_id, 0);
        @(negedge clk);
        check("A_busy_after", busy, 0);
        check("A_rsp_valid_after", rsp_valid, 0);

        // req1 and req3 together right after reset
        pulse_reset();
        rsp_log.delete();
        req_valid = 4'b1010;
        req_a[15:8] = 8'd20; req_b[15:8] = 8'd32;
        req_a[31:24] = 8'd10; req_b[31:24] = 8'd30;
        drive_until_idle(30);
        check("B_count", rsp_log.size(), 2);
        if (rsp_log.size() >= 2) begin
            check("B_first", rsp_log[0], {2'd1, 16'd640});
            check("B_second", rsp_log[1], {2'd3, 16'd300});
        end
        req_valid = 4'b0011;
        req_a[7:0] = 8'd5; req_b[7:0] = 8'd5;
        @(negedge clk) check("B_rr_wrap", req_ready, 4'b0001);
        drive_until_idle(30);

        // all four valid continuously, 8 operations
        pulse_reset();
        req_valid = 4'b1111; req_a = $urandom; req_b = $urandom; rsp_ready = 1;
        g = 0;
        for (int c = 0; c < 100 && g < 8; c++) begin
            @(posedge clk);
            hs = req_ready & req_valid;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    order.push_back(i);
                    g++;
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                end
            end
            if (g >= 8) req_valid = '0;
        end
        check("C_grants", g, 8);
        for (int k = 0; k < order.size() && k < 8; k++) check("C_order", order[k], k % 4);
        drive_until_idle(30);

        // response held off for 5 cycles
        req_valid = 4'b0001; req_a[7:0] = 8'd7; req_b[7:0] = 8'd9; rsp_ready = 0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(posedge clk);
            hs = req_ready & req_valid;
            #1;
            if (hs[0]) begin
                got = 1;
                req_valid = 4'b0010; req_a[15:8] = 8'd1; req_b[15:8] = 8'd2;
            end
        end
        check("D_grant", got, 1);
        for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("D_hold_valid", rsp_valid, 1);
            check("D_hold_y", rsp_y, 16'd63);
            check("D_hold_id", rsp_id, 0);
            check("D_hold_noready", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        check("D_accept_valid", rsp_valid, 1);
        check("D_accept_noready", req_ready, 0);
        @(negedge clk);
        check("D_next_ready", req_ready, 4'b0010);
        drive_until_idle(30);

        // randomized traffic
        rand_phase(800);
        rsp_ready = 1;
        req_valid = '0;
        drive_until_idle(40);

        // MUL_LAT=4 instance: 3*3
        @(posedge clk); #1;
        v2 = 4'b0001; a2[7:0] = 8'd3; b2[7:0] = 8'd3; rr2 = 1;
        @(negedge clk);
        check("F_ready", rdy2, 4'b0001);
        check("F_idle", busy2, 0);
        @(posedge clk); #1 v2 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("F_wait_valid", rv2, 0);
            check("F_wait_busy", busy2, 1);
        end
        @(negedge clk);
        check("F_rsp_valid", rv2, 1);
        check("F_rsp_y", y2, 16'd7);
        check("F_rsp_id", id2, 0);
        check("F_rsp_err", err2, ERR_EN ? 16'd2 : 16'd0);
        $display("[TB] txn lat4 id=%0d a=3 b=3 y=%0d err=%0d", id2, y2, err2);
        @(negedge clk);
        check("F_done_busy", busy2, 0);
        check("F_done_valid", rv2, 0);

        // reset while in MUL
        @(posedge clk); #1;
        v2 = 4'b0010; a2[15:8] = 8'd5; b2[15:8] = 8'd6;
        @(posedge clk); #1 v2 = '0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("R_valid", rv2, 0);
        check("R_y", y2, 0);
        check("R_id", id2, 0);
        check("R_err", err2, 0);
        check("R_ma", ma2, 0);
        check("R_mb", mb2, 0);
        check("R_busy", busy2, 0);
        check("R_ready", rdy2, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk) check("R_no_rsp", rv2, 0);
        end
        @(posedge clk); #1;
        v2 = 4'b0011; a2[7:0] = 8'd12; b2[7:0] = 8'd13; a2[15:8] = 8'd1; b2[15:8] = 8'd1;
        @(negedge clk) check("R_rr_reset", rdy2, 4'b0001);
        @(posedge clk); #1 v2 = '0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("R2_valid", rv2, 1);
        check("R2_y", y2, 16'd124);
        check("R2_id", id2, 0);
        check("R2_err", err2, ERR_EN ? 16'd32 : 16'd0);
        $display("[TB] txn lat4 id=%0d a=12 b=13 y=%0d err=%0d", id2, y2, err2);
        @(negedge clk);
        check("R2_done", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Time-shares one combinational approx_8x8 multiplier among N_REQ requesters.
- Each requester uses a valid/ready request channel; arbitration is round-robin.
- The controller latches operands, drives the multiplier, and waits MUL_LAT cycles for the path to settle.
- It returns the product with the requester ID on a single valid/ready response channel, with backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, response ID width (>= clog2(N_REQ)).
- MUL_LAT, 1, cycles operands are held before mult_y is sampled (1..15).

Ports:
- clk  input  1  system clock (all logic rises on posedge clk).
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  8*N_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*N_REQ  operand B; same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_y  output  16  product as returned by the multiplier.
- rsp_id  output  ID_W  index of the requester that owns rsp_y.
- rsp_err  output  16  |exact - approx| (see Optional Feature).
- mult_a  output  8  operand A to approx_8x8.
- mult_b  output  8  operand B to approx_8x8.
- mult_y  input  16  approx_8x8 output.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0.
  - rsp_y=0, rsp_id=0, rsp_err=0, mult_a=0, mult_b=0, busy=0.
- States: IDLE, MUL, RSP.
- IDLE:
  - req_ready is combinational: one-hot to the winner, only when state==IDLE and any req_valid is high.
  - Winner = first asserted req_valid searching upward from rr_ptr, wrapping N_REQ-1 to 0.
  - On handshake: latch winner's req_a/req_b into mult_a/mult_b, latch ID, cnt=MUL_LAT-1, rr_ptr=(winner+1) mod N_REQ, go to MUL.
  - If no req_valid: stay in IDLE; rr_ptr unchanged.
- MUL:
  - mult_a/mult_b held stable. req_ready=0 for all requesters.
  - If cnt==0: rsp_y<=mult_y, rsp_id<=latched ID, rsp_valid<=1, go to RSP. Otherwise cnt decrements.
  - The MUL_LAT=1 case gives exactly one cycle in MUL.
- RSP:
  - rsp_valid stays high; rsp_y/rsp_id/rsp_err stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
  - With rsp_ready held high, RSP lasts one cycle.
- Latency, handshake to rsp_valid: MUL_LAT+1 cycles. Peak throughput: one op per MUL_LAT+2 cycles.
- Requests arriving outside IDLE are not accepted. A requester must hold req_valid and its operands until it sees req_ready.
- Simultaneous requests: only the round-robin winner is served; the others remain pending with no loss.
- A requester that drops req_valid before being granted is ignored (no error).
- Reset mid-operation: the in-flight transaction is discarded and no response is issued. Every register returns to its reset value in the same cycle.
- mult_a/mult_b keep their last values in IDLE; they change only on a grant.

Optional Feature:
- Macro: MULT_SHARE_ERR_CHECK_EN.
- Defined:
  - At the MUL->RSP transition, compute the exact product mult_a*mult_b (16 bit).
  - rsp_err <= absolute difference to mult_y; valid with rsp_valid.
  - Adds no cycles.
- Not defined: rsp_err is tied to 0 and no exact multiplier is synthesised.

Test Plan:
- Single request, a=10, b=32, MUL_LAT=1, rsp_ready=1 -> req0 ready 1 cycle; rsp_valid 2 cycles after handshake, rsp_y=320, rsp_id=0; busy low the cycle after the response.
- req1 (20,32) and req3 (10,30) held together from reset -> req1 served first (y=640, id=1), then req3 (y=300, id=3); next grant search starts at index 0.
- All four requesters valid continuously, 8 ops -> grant order 0,1,2,3,0,1,2,3; no requester starved.
- rsp_ready low for 5 cycles during RSP -> rsp_valid, rsp_y and rsp_id stable throughout; no new req_ready until the cycle after acceptance.
- MUL_LAT=4, a=3, b=3 -> rsp_valid 5 cycles after handshake. rsp_y=7 (approximate 2x2 block); with MULT_SHARE_ERR_CHECK_EN, rsp_err=2, otherwise rsp_err=0.
- rst_n low for 1 cycle while in MUL -> no rsp_valid; all outputs 0; rr_ptr=0; the next request is granted normally.
